seq_divider: RTL

//  Multi-cycle restoring divider: one quotient bit per clock, unsigned by default.

---
 rtl/seq_div_pkg.sv | 20 ++
 rtl/seq_div_step.sv | 28 ++
 rtl/seq_divider.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and constants for the sequential divider
//   DIV_WIDTH  - default operand width, shared with the divider register block
//   state_t    - divider FSM states (IDLE, RUN, FIXUP, DONE)
//   cnt_width  - iteration counter width for a given operand width
package seq_div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one combinational restoring-division iteration
//   rem_in  - partial remainder before this step (always < denom)
//   q_in    - dividend/quotient shift register; its MSB is the next dividend bit
//   denom   - divisor
//   rem_out - partial remainder after the conditional subtract
//   q_out   - shift register with the new quotient bit shifted into the LSB
module seq_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] denom,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    // One extra bit keeps the shifted remainder exact when denom uses the MSB.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_in, q_in[WIDTH-1]};
        diff    = shifted - {1'b0, denom};
        rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], ~diff[WIDTH]};
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock
//   clk         - clock, all state on posedge
//   reset_n     - asynchronous active-low reset
//   start       - request, accepted only while ready=1
//   numer/denom - operands, sampled on the accepting edge
//   ready       - high in IDLE and DONE
//   done        - one-cycle pulse when quotient/remain/div_by_zero are valid
//   quotient    - result, held until the next accepted start
//   remain      - remainder, held until the next accepted start
//   div_by_zero - set with done when denom was zero
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's complement operands
// (adds a FIXUP cycle that applies the result signs).
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] numer,
    input  logic [WIDTH-1:0] denom,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remain,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fin_q, fin_d;
    logic             dbzp_q, dbzp_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic [WIDTH-1:0] step_rem, step_work;
    logic [WIDTH-1:0] num_mag, den_mag;
    logic             accept, dz;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    assign num_mag = numer[WIDTH-1] ? -numer : numer;
    assign den_mag = denom[WIDTH-1] ? -denom : denom;
`else
    assign num_mag = numer;
    assign den_mag = denom;
`endif

    assign accept = ready_q && start;
    assign dz     = (denom == '0);

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .q_in    (work_q),
        .denom   (den_q),
        .rem_out (step_rem),
        .q_out   (step_work)
    );

    // fin marks that the last iteration has happened; the following RUN edge
    // publishes the result. A zero divisor enters RUN already finished, which
    // gives the single-edge divide-by-zero latency with no iterations.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        dbzp_d  = dbzp_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        rem_d   = rem_q;
        work_d  = work_q;
        den_d   = den_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            fin_d   = dz;
            dbzp_d  = dz;
            ready_d = 1'b0;
            dbz_d   = 1'b0;
            rem_d   = '0;
            den_d   = den_mag;
            // On divide-by-zero the raw numerator is kept for the remainder.
            work_d  = dz ? numer : num_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_d  = numer[WIDTH-1] ^ denom[WIDTH-1];
            rneg_d  = numer[WIDTH-1];
`endif
        end else begin
            case (state_q)
                RUN: begin
                    if (!fin_q) begin
                        rem_d  = step_rem;
                        work_d = step_work;
                        cnt_d  = cnt_q + 1'b1;
                        fin_d  = (cnt_q == LAST);
                    end else if (dbzp_q) begin
                        quo_d   = '1;
                        remo_d  = work_q;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                        state_d = FIXUP;
`else
                        quo_d   = work_q;
                        remo_d  = rem_q;
                        state_d = DONE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
`endif
                    end
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                FIXUP: begin
                    quo_d   = qneg_q ? -work_q : work_q;
                    remo_d  = rneg_q ? -rem_q : rem_q;
                    state_d = DONE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
`endif
                DONE: state_d = IDLE;
                default: begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            dbzp_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            rem_q   <= '0;
            work_q  <= '0;
            den_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            dbzp_q  <= dbzp_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            den_q   <= den_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remain      = remo_q;
    assign div_by_zero = dbz_q;

endmodule
